// File: rtl/feature_map_pkg.sv
// Constants, FSM state and FIFO payload for the feature-map row reader.
// Build option DATA_RAM_RD_PAD_EN is resolved in data_ram_rd.
package feature_map_pkg;

  localparam int unsigned MAP_DIM = 28;
  localparam int unsigned PAD_DIM = 30;
  localparam int unsigned ROW_W   = 30;
  localparam int unsigned ADDR_W  = 5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } rd_state_t;

  typedef struct packed {
    logic [ROW_W-1:0]  data;
    logic [ADDR_W-1:0] idx;
    logic              last;
  } row_t;

endpackage

// File: rtl/row_fifo2.sv
// Two-entry row FIFO; head entry is registered and
// stays put until popped.
module row_fifo2
  import feature_map_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  row_t din,
  output row_t dout,
  output logic full,
  output logic empty
);

  row_t       mem [2];
  logic       wp;
  logic       rp;
  logic [1:0] cnt;
  logic       do_push;
  logic       do_pop;

  assign full    = cnt == 2'd2;
  assign empty   = cnt == 2'd0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wp] <= din;
        wp      <= ~wp;
      end
      if (do_pop)
        rp <= ~rp;
      cnt <= cnt + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/data_ram_rd.sv
// Streams a stored 28x28 bit map out row by row with valid/ready.
// Define DATA_RAM_RD_PAD_EN to add all-zero border rows/columns.
module data_ram_rd
  import feature_map_pkg::*;
(
  input  logic               sclk,
  input  logic               s_rst,
  input  logic               frame_start,
  output logic               ram_enb,
  output logic [ADDR_W-1:0]  ram_addrb,
  input  logic [MAP_DIM-1:0] ram_doutb,
  output logic [ROW_W-1:0]   row_data,
  output logic               row_valid,
  input  logic               row_ready,
  output logic [ADDR_W-1:0]  row_idx,
  output logic               row_last,
  output logic               busy,
  output logic               frame_done,
  output logic               start_err
);

`ifdef DATA_RAM_RD_PAD_EN
  localparam int unsigned NROWS = PAD_DIM;
`else
  localparam int unsigned NROWS = MAP_DIM;
`endif
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(NROWS - 1);

  rd_state_t         state;
  logic [ADDR_W-1:0] row_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] cap_idx;
  logic              cap_vld;
  logic              cap_pad;
  logic              pad_row;
  logic              issue;
  logic              pop;
  logic              full;
  logic              empty;
  logic [2:0]        load;
  logic [ROW_W-1:0]  cap_data;
  row_t              cap_row;
  row_t              head;

`ifdef DATA_RAM_RD_PAD_EN
  assign pad_row  = row_cnt == '0 || row_cnt == LAST_ROW;
  assign rd_addr  = row_cnt - ADDR_W'(1);
  assign cap_data = cap_pad ? '0 : {1'b0, ram_doutb, 1'b0};
`else
  assign pad_row  = 1'b0;
  assign rd_addr  = row_cnt;
  assign cap_data = cap_pad ? '0 : {2'b00, ram_doutb};
`endif

  // queued + in-flight rows, net of this cycle's pop, must stay below 2
  assign pop   = row_valid && row_ready;
  assign load  = (full ? 3'd2 : (empty ? 3'd0 : 3'd1)) + 3'(cap_vld);
  assign issue = state == RUN && load < 3'd2 + 3'(pop);

  assign ram_enb   = issue && !pad_row;
  assign ram_addrb = ram_enb ? rd_addr : addr_q;

  assign cap_row = '{
    data: cap_data,
    idx:  cap_idx,
    last: cap_idx == LAST_ROW
  };

  row_fifo2 u_fifo (
    .clk   (sclk),
    .rst   (s_rst),
    .push  (cap_vld),
    .pop   (pop),
    .din   (cap_row),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign row_valid = !empty;
  assign row_data  = head.data;
  assign row_idx   = head.idx;
  assign row_last  = head.last;

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      start_err  <= 1'b0;
      row_cnt    <= '0;
      addr_q     <= '0;
      cap_vld    <= 1'b0;
      cap_idx    <= '0;
      cap_pad    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      start_err  <= frame_start && state != IDLE;
      cap_vld    <= issue;
      cap_idx    <= row_cnt;
      cap_pad    <= pad_row;
      if (ram_enb)
        addr_q <= rd_addr;
      unique case (state)
        IDLE: begin
          if (frame_start) begin
            state   <= RUN;
            busy    <= 1'b1;
            row_cnt <= '0;
          end
        end
        RUN: begin
          if (issue) begin
            row_cnt <= row_cnt + ADDR_W'(1);
            if (row_cnt == LAST_ROW)
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && row_last)
            state <= DONE;
        end
        DONE: begin
          state      <= IDLE;
          busy       <= 1'b0;
          frame_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_ram_rd.sv
// Self-checking bench for data_ram_rd: timing tables, stall,
// restart, mid-frame reset and randomized frames vs a row model.
module tb_data_ram_rd;
  import feature_map_pkg::*;

`ifdef DATA_RAM_RD_PAD_EN
  localparam int N   = PAD_DIM;
  localparam bit PAD = 1'b1;
`else
  localparam int N   = MAP_DIM;
  localparam bit PAD = 1'b0;
`endif

  logic        sclk = 1'b0;
  logic        s_rst;
  logic        frame_start;
  logic        ram_enb;
  logic [4:0]  ram_addrb;
  logic [27:0] ram_doutb;
  logic [29:0] row_data;
  logic        row_valid;
  logic        row_ready;
  logic [4:0]  row_idx;
  logic        row_last;
  logic        busy;
  logic        frame_done;
  logic        start_err;

  logic [27:0] mem [32];

  int checks;
  int errors;
  int exp_idx;
  int rows_seen;
  int enb_cnt;
  int xfer_cnt;
  logic [4:0]  last_addr;
  logic        stall_q;
  logic [29:0] hold_data;
  logic [4:0]  hold_idx;
  logic        hold_last;

  typedef struct {
    logic fs;
    logic enb;
    logic vld;
    logic bsy;
    logic done;
    logic err;
  } vec_t;

  vec_t tbl [N+6];

  data_ram_rd dut (
    .sclk        (sclk),
    .s_rst       (s_rst),
    .frame_start (frame_start),
    .ram_enb     (ram_enb),
    .ram_addrb   (ram_addrb),
    .ram_doutb   (ram_doutb),
    .row_data    (row_data),
    .row_valid   (row_valid),
    .row_ready   (row_ready),
    .row_idx     (row_idx),
    .row_last    (row_last),
    .busy        (busy),
    .frame_done  (frame_done),
    .start_err   (start_err)
  );

  always #5 sclk = ~sclk;

  // column RAMs: registered read, data one cycle after enable
  always @(posedge sclk)
    if (ram_enb)
      ram_doutb <= mem[ram_addrb];

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic logic [29:0] model_row(input int r);
    logic [29:0] v;
    v = '0;
    if (PAD) begin
      if (r > 0 && r < N - 1)
        v = 30'(mem[r-1]) * 30'd2;
    end else begin
      v = 30'(mem[r]);
    end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic reset_sb();
    exp_idx   = 0;
    rows_seen = 0;
    enb_cnt   = 0;
    xfer_cnt  = 0;
  endtask

  task automatic chk_rst();
    chk("rst_valid", 32'(row_valid), 32'd0);
    chk("rst_enb",   32'(ram_enb),   32'd0);
    chk("rst_addr",  32'(ram_addrb), 32'd0);
    chk("rst_data",  32'(row_data),  32'd0);
    chk("rst_idx",   32'(row_idx),   32'd0);
    chk("rst_last",  32'(row_last),  32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_done",  32'(frame_done), 32'd0);
    chk("rst_err",   32'(start_err), 32'd0);
  endtask

  // per-cycle scoreboard, called at the falling edge
  task automatic mon();
    if (row_valid)
      chk("last_only_final", 32'(row_last), 32'(row_idx == 5'(N - 1)));
    if (stall_q) begin
      chk("stall_valid", 32'(row_valid), 32'd1);
      chk("stall_data",  32'(row_data),  32'(hold_data));
      chk("stall_idx",   32'(row_idx),   32'(hold_idx));
      chk("stall_last",  32'(row_last),  32'(hold_last));
    end
    if (ram_enb) begin
      enb_cnt++;
      chk("addr_range", 32'(ram_addrb < 5'd28), 32'd1);
      last_addr = ram_addrb;
    end else begin
      chk("addr_hold", 32'(ram_addrb), 32'(last_addr));
    end
    if (row_valid && row_ready) begin
      xfer_cnt++;
      rows_seen++;
      chk("row_idx",  32'(row_idx),  32'(exp_idx));
      chk("row_data", 32'(row_data), 32'(model_row(exp_idx)));
      exp_idx = (exp_idx == N - 1) ? 0 : exp_idx + 1;
    end
    if (ram_enb)
      chk("outstanding", 32'(enb_cnt - xfer_cnt <= 2), 32'd1);
    stall_q   = row_valid && !row_ready;
    hold_data = row_data;
    hold_idx  = row_idx;
    hold_last = row_last;
  endtask

  task automatic tick();
    @(negedge sclk);
    mon();
    @(posedge sclk);
    #1;
  endtask

  task automatic run_table(input bit dup);
    for (int c = 0; c < N + 6; c++) begin
      tbl[c].fs   = (c == 0) || (dup && c == 5);
      tbl[c].enb  = PAD ? (c >= 2 && c <= N - 1) : (c >= 1 && c <= N);
      tbl[c].vld  = c >= 3 && c <= N + 2;
      tbl[c].bsy  = c >= 1 && c <= N + 3;
      tbl[c].done = c == N + 4;
      tbl[c].err  = dup && c == 6;
    end
    reset_sb();
    row_ready = 1'b1;
    for (int c = 0; c < N + 6; c++) begin
      frame_start = tbl[c].fs;
      @(negedge sclk);
      chk("t_enb",  32'(ram_enb),    32'(tbl[c].enb));
      chk("t_vld",  32'(row_valid),  32'(tbl[c].vld));
      chk("t_busy", 32'(busy),       32'(tbl[c].bsy));
      chk("t_done", 32'(frame_done), 32'(tbl[c].done));
      chk("t_err",  32'(start_err),  32'(tbl[c].err));
      mon();
      @(posedge sclk);
      #1;
    end
    frame_start = 1'b0;
    chk("t_rows", 32'(rows_seen), 32'(N));
    chk("t_enb_total", 32'(enb_cnt), 32'(MAP_DIM));
  endtask

  task automatic run_stall();
    int  k;
    bit  seen;
    k    = 0;
    seen = 1'b0;
    reset_sb();
    while (!seen && k < 400) begin
      frame_start = k == 0;
      row_ready   = (k % 4 == 0) || (k % 4 == 3);
      @(negedge sclk);
      if (frame_done)
        seen = 1'b1;
      mon();
      @(posedge sclk);
      #1;
      k++;
    end
    frame_start = 1'b0;
    row_ready   = 1'b1;
    chk("stall_done_seen", 32'(seen), 32'd1);
    chk("stall_rows", 32'(rows_seen), 32'(N));
  endtask

  task automatic run_mid_reset();
    reset_sb();
    row_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      frame_start = c == 0;
      tick();
    end
    s_rst = 1'b1;
    tick();
    s_rst     = 1'b0;
    last_addr = '0;
    stall_q   = 1'b0;
    reset_sb();
    @(negedge sclk);
    chk_rst();
    mon();
    for (int c = 0; c < 3; c++) begin
      @(posedge sclk);
      #1;
      @(negedge sclk);
      chk("discard_valid", 32'(row_valid), 32'd0);
      mon();
    end
    @(posedge sclk);
    #1;
    run_table(1'b0);
  endtask

  task automatic run_random();
    int  k;
    int  frames;
    bit  active;
    bit  fs;
    bit  err_exp;
    bit  acc_prev;
    k        = 0;
    frames   = 0;
    active   = 1'b0;
    err_exp  = 1'b0;
    acc_prev = 1'b0;
    for (int r = 0; r < MAP_DIM; r++)
      mem[r] = 28'($urandom);
    reset_sb();
    while (frames < 4 && k < 4000) begin
      fs = 1'b0;
      if (frame_done) begin
        frames++;
        active = 1'b0;
      end
      if (k == 0 || (frame_done && frames < 4))
        fs = 1'b1;
      else if (active && $urandom_range(0, 19) == 0)
        fs = 1'b1;
      frame_start = fs;
      row_ready   = 1'($urandom_range(0, 1));
      @(negedge sclk);
      chk("r_start_err", 32'(start_err), 32'(err_exp));
      if (acc_prev)
        chk("r_busy_after_start", 32'(busy), 32'd1);
      mon();
      err_exp  = fs && active;
      acc_prev = fs && !active;
      if (fs && !active)
        active = 1'b1;
      @(posedge sclk);
      #1;
      k++;
    end
    frame_start = 1'b0;
    row_ready   = 1'b1;
    chk("r_frames", 32'(frames), 32'd4);
    chk("r_rows", 32'(rows_seen), 32'(4 * N));
    repeat (3) tick();
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    s_rst       = 1'b1;
    frame_start = 1'b0;
    row_ready   = 1'b0;
    ram_doutb   = '0;
    last_addr   = '0;
    stall_q     = 1'b0;
    hold_data   = '0;
    hold_idx    = '0;
    hold_last   = 1'b0;
    for (int r = 0; r < 32; r++)
      mem[r] = '0;
    reset_sb();
    repeat (3) @(posedge sclk);
    #1;
    @(negedge sclk);
    chk_rst();
    @(posedge sclk);
    #1;
    s_rst = 1'b0;
    repeat (2) tick();

    for (int r = 0; r < MAP_DIM; r++)
      mem[r] = 28'(r * 32'h0492461);
    run_table(1'b0);
    run_table(1'b1);
    run_stall();
    repeat (2) tick();
    run_mid_reset();
    run_random();

    for (int r = 0; r < MAP_DIM; r++)
      mem[r] = 28'hFFF_FFFF;
    run_table(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_ram_rd.md
DATA_RAM_RD -- requirements
Module: data_ram_rd

Interface
REQ-001 SHALL have port sclk, input, 1: single clock; all logic rising-edge.
REQ-002 SHALL have port s_rst, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have port frame_start, input, 1: one-cycle pulse; begins readout of a stored 28x28 1-bit map.
REQ-004 SHALL have port ram_enb, output, 1: read enable to all 28 column RAMs, port B.
REQ-005 SHALL have port ram_addrb, output, 5: shared row address, 0..27.
REQ-006 SHALL have port ram_doutb, input, 28: bit k = column k of the addressed row; valid one cycle after ram_enb.
REQ-007 SHALL have port row_data, output, 30: row word; bit 0 = leftmost column.
REQ-008 SHALL have ports row_valid, output, 1, and row_ready, input, 1: transfer when both are high on a rising edge.
REQ-009 SHALL have port row_idx, output, 5: index of the presented row.
REQ-010 SHALL have port row_last, output, 1: presented row is final row of frame.
REQ-011 SHALL have port busy, output, 1: high from the cycle after an accepted frame_start until frame_done.
REQ-012 SHALL have port frame_done, output, 1: one-cycle pulse after last row transfer.
REQ-013 SHALL have port start_err, output, 1: one-cycle pulse when frame_start arrives while busy.

Function
REQ-014 SHALL implement FSM IDLE->RUN (frame_start in IDLE), RUN->DRAIN (final row issued), DRAIN->DONE (final row transferred), DONE->IDLE (unconditional, frame_done=1 in DONE).
REQ-015 SHALL ignore frame_start outside IDLE, pulse start_err, and leave the current frame undisturbed.
REQ-016 SHALL issue rows in order 0..N-1 (N=28, or 30 with padding), one per cycle max, only in RUN.
REQ-017 SHALL issue a row only when FIFO entries + in-flight reads - (transfer this cycle) < 2, so no row is dropped or overwritten under backpressure.
REQ-018 SHALL capture ram_doutb into a 2-entry output FIFO exactly one cycle after the matching ram_enb; row_valid high in the cycle after capture (issue-to-valid latency 2 cycles).
REQ-019 SHALL sustain one row per cycle while row_ready is held high.
REQ-020 SHALL hold row_data, row_idx and row_last stable while row_valid=1 and row_ready=0.
REQ-021 SHALL drive ram_enb=0 and ram_addrb unchanged whenever no read is issued.
REQ-022 SHALL assert row_last only with row_idx=N-1.
REQ-023 SHALL accept frame_start in the cycle directly after DONE, i.e. back-to-back frames in IDLE.

Reset
REQ-024 SHALL on s_rst=1, at any time including mid-frame, force state IDLE, empty FIFO, clear in-flight tracking; following cycle: row_valid=0, ram_enb=0, ram_addrb=0, row_data=0, row_idx=0, row_last=0, busy=0, frame_done=0, start_err=0.
REQ-025 SHALL discard RAM data returning after reset.

Configuration
REQ-026 SHALL support macro DATA_RAM_RD_PAD_EN: when defined, N=30, rows 0 and 29 all-zero and issued without ram_enb, rows 1..28 carry RAM row r-1 in bits [28:1] with bits 0 and 29 zero; pad rows use the same 2-cycle latency and FIFO.
REQ-027 SHALL without DATA_RAM_RD_PAD_EN use N=28, row r = RAM row r in bits [27:0], bits [29:28] zero.

Structure
REQ-028 SHALL take MAP_DIM=28, PAD_DIM=30, ROW_W=30, ADDR_W=5 and the FSM state enum from shared package feature_map_pkg.
REQ-029 SHALL place the output FIFO in sub-module row_fifo2 (2-entry, 30+5+1 bits wide, push/pop/full/empty).

Verification
REQ-030 SHALL cover: RAM row r preloaded with pattern r*0x0492461 masked to 28 bits, row_ready=1, frame_start at cycle 0 -> ram_enb cycles 1..28, row_valid cycles 3..30, 28 rows match, row_last at row 27, frame_done cycle 32.
REQ-031 SHALL cover: row_ready toggled 1,0,0,1 repeating -> all 28 rows in order, none duplicated, data stable while stalled, no more than 2 outstanding reads.
REQ-032 SHALL cover: frame_start repeated at cycle 5 -> start_err pulse at cycle 6, frame output unchanged.
REQ-033 SHALL cover: s_rst at cycle 10 mid-frame -> all outputs at reset values in cycle 11, fresh frame_start yields complete frame from row 0.
REQ-034 SHALL cover: DATA_RAM_RD_PAD_EN defined, all-ones RAM -> 30 rows; rows 0, 29 = 0; rows 1..28 = 0x1FFFFFFE; 28 ram_enb pulses total.
